// File: rtl/uart_tx_arbiter.sv
// N-channel round-robin arbiter feeding one shared UART transmitter from per-channel word FIFOs.
// Optional line lock (keep grant until a 0x0A byte) is enabled by defining UART_ARB_LINE_LOCK_EN.
module uart_tx_arbiter #(
    parameter int NUM_CH           = 2,
    parameter int FIFO_DEPTH       = 64,
    parameter int CLKS_PER_BIT_VAL = 4,
    parameter int LOCK_TIMEOUT     = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   s_wvalid,
    input  logic [NUM_CH*32-1:0] s_wdata,
    input  logic [NUM_CH*4-1:0] s_wstrb,
    output logic [NUM_CH-1:0]   s_wready,
    output logic [NUM_CH-1:0]   s_status,
    output logic                i_Tx_DV,
    output logic [7:0]          i_Tx_Byte,
    input  logic                o_Tx_Active,
    input  logic                o_Tx_Done,
    output logic [7:0]          CLKS_PER_BIT
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
    state_t state, state_next;

    logic [35:0]    mem [NUM_CH][FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr [NUM_CH];
    logic [PW-1:0]  rd_ptr [NUM_CH];
    logic [CW-1:0]  count [NUM_CH];
    logic [NUM_CH-1:0] push, pop, nonempty;

    logic [GW-1:0]  last_gnt, gnt;
    logic           gnt_valid;
    logic [35:0]    head;
    logic [31:0]    hold_data;
    logic [3:0]     hold_strb, low_strb, strb_left;
    logic           turn;

    assign CLKS_PER_BIT = 8'(CLKS_PER_BIT_VAL);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            nonempty[i] = (count[i] != '0);
            s_wready[i] = (count[i] != CW'(FIFO_DEPTH));
            s_status[i] = (count[i] <= CW'(FIFO_DEPTH - 2));
        end
    end

    assign push = s_wvalid & s_wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
                if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
                else if (pop[i] && !push[i]) count[i] <= count[i] - CW'(1);
            end
        end
    end

    // Storage is not reset; the pointer/count reset is what flushes the FIFOs.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= {s_wstrb[4*i +: 4], s_wdata[32*i +: 32]};
        end
    end

`ifdef UART_ARB_LINE_LOCK_EN
    localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
    logic          lock_valid;
    logic [GW-1:0] lock_ch;
    logic [TW-1:0] lock_tmr;
`endif

    always_comb begin
        logic [GW-1:0] idx;
        idx       = '0;
        gnt       = last_gnt;
        gnt_valid = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = GW'((int'(last_gnt) + i) % NUM_CH);
            if (!gnt_valid && nonempty[idx]) begin
                gnt       = idx;
                gnt_valid = 1'b1;
            end
        end
`ifdef UART_ARB_LINE_LOCK_EN
        // A held lock waits for its own channel even if others have data.
        if (lock_valid) begin
            gnt       = lock_ch;
            gnt_valid = nonempty[lock_ch];
        end
`endif
    end

    always_comb begin
        pop = '0;
        if (state == IDLE && gnt_valid) pop[gnt] = 1'b1;
    end

    assign head      = mem[gnt][rd_ptr[gnt]];
    assign low_strb  = hold_strb & (~hold_strb + 4'd1);
    assign strb_left = hold_strb & ~low_strb;

    always_comb begin
        if (hold_strb[0])      i_Tx_Byte = hold_data[7:0];
        else if (hold_strb[1]) i_Tx_Byte = hold_data[15:8];
        else if (hold_strb[2]) i_Tx_Byte = hold_data[23:16];
        else if (hold_strb[3]) i_Tx_Byte = hold_data[31:24];
        else                   i_Tx_Byte = hold_data[7:0];
    end

    // turn holds off the start pulse for one cycle after each Done.
    always_comb begin
        state_next = state;
        i_Tx_DV    = 1'b0;
        case (state)
            IDLE: if (gnt_valid && head[35:32] != 4'b0000) state_next = SEND;
            SEND: if (!o_Tx_Active && !turn) begin
                i_Tx_DV    = 1'b1;
                state_next = WAIT;
            end
            WAIT: if (o_Tx_Done) state_next = (strb_left != 4'b0000) ? SEND : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= GW'(NUM_CH - 1);
            hold_data <= '0;
            hold_strb <= '0;
            turn      <= 1'b0;
        end else begin
            state <= state_next;
            turn  <= (state == WAIT) && o_Tx_Done;
            if (state == IDLE && gnt_valid) begin
                last_gnt  <= gnt;
                hold_data <= head[31:0];
                hold_strb <= head[35:32];
            end
            if (state == WAIT && o_Tx_Done) hold_strb <= strb_left;
        end
    end

`ifdef UART_ARB_LINE_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_valid <= 1'b0;
            lock_ch    <= '0;
            lock_tmr   <= '0;
        end else if (state == WAIT && o_Tx_Done && strb_left == 4'b0000) begin
            lock_valid <= (i_Tx_Byte != 8'h0A);
            lock_ch    <= last_gnt;
            lock_tmr   <= TW'(LOCK_TIMEOUT - 1);
        end else if (lock_valid) begin
            if (nonempty[lock_ch])   lock_tmr   <= TW'(LOCK_TIMEOUT - 1);
            else if (lock_tmr == '0) lock_valid <= 1'b0;
            else                     lock_tmr   <= lock_tmr - TW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UART model (3 busy cycles, then Done).
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  s_wvalid;
    logic [63:0] s_wdata;
    logic [7:0]  s_wstrb;
    logic [1:0]  s_wready, s_status;
    logic        i_Tx_DV;
    logic [7:0]  i_Tx_Byte;
    logic        o_Tx_Active;
    logic        o_Tx_Done;
    logic [7:0]  CLKS_PER_BIT;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_done = 0;
    int ucnt = 0;
    logic uart_busy = 1'b0;
    logic hold_active = 1'b0;
    logic [7:0] byte_q[$];
    int cyc_q[$];
    int gap_q[$];

    uart_tx_arbiter #(.NUM_CH(2), .FIFO_DEPTH(64), .CLKS_PER_BIT_VAL(4), .LOCK_TIMEOUT(1024)) dut (
        .clk(clk), .rst(rst), .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wready(s_wready), .s_status(s_status), .i_Tx_DV(i_Tx_DV), .i_Tx_Byte(i_Tx_Byte),
        .o_Tx_Active(o_Tx_Active), .o_Tx_Done(o_Tx_Done), .CLKS_PER_BIT(CLKS_PER_BIT)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign o_Tx_Active = uart_busy | hold_active;

    always @(negedge clk) begin
        if (o_Tx_Done) last_done = cyc;
        if (i_Tx_DV) begin
            byte_q.push_back(i_Tx_Byte);
            cyc_q.push_back(cyc);
            gap_q.push_back(cyc - last_done);
        end
    end

    initial begin
        logic dv_s;
        o_Tx_Done = 1'b0;
        forever begin
            @(negedge clk);
            dv_s = i_Tx_DV;
            @(posedge clk);
            #1;
            o_Tx_Done = 1'b0;
            if (ucnt > 0) begin
                ucnt--;
                if (ucnt == 0) begin
                    o_Tx_Done = 1'b1;
                    uart_busy = 1'b0;
                end
            end else if (dv_s) begin
                uart_busy = 1'b1;
                ucnt = 3;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] v, input logic [63:0] d, input logic [7:0] s);
        s_wvalid = v;
        s_wdata  = d;
        s_wstrb  = s;
        step();
        s_wvalid = 2'b00;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (byte_q.size() < n && k < budget) begin
            step();
            k++;
        end
        repeat (12) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_wvalid = 2'b00; s_wdata = '0; s_wstrb = '0; hold_active = 1'b0;
        repeat (3) step();
        n_cmp++; if (i_Tx_DV !== 1'b0) begin n_err++; $display("FAIL reset_dv: got %0h want 0", i_Tx_DV); end
        n_cmp++; if (i_Tx_Byte !== 8'h00) begin n_err++; $display("FAIL reset_byte: got %0h want 0", i_Tx_Byte); end
        n_cmp++; if (s_wready !== 2'b11) begin n_err++; $display("FAIL reset_wready: got %b want 11", s_wready); end
        n_cmp++; if (s_status !== 2'b11) begin n_err++; $display("FAIL reset_status: got %b want 11", s_status); end
        n_cmp++; if (CLKS_PER_BIT !== 8'd4) begin n_err++; $display("FAIL clks_per_bit: got %0d want 4", CLKS_PER_BIT); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_byte();
        int b0 = byte_q.size();
        int p = cyc;
        push(2'b01, 64'h41, 8'h01);
        wait_bytes(b0 + 1, 40);
        n_cmp++; if (byte_q.size() !== b0 + 1) begin n_err++; $display("FAIL single_count: got %0d want %0d", byte_q.size() - b0, 1); end
        if (byte_q.size() > b0) begin
            n_cmp++; if (byte_q[b0] !== 8'h41) begin n_err++; $display("FAIL single_byte: got %0h want 41", byte_q[b0]); end
            n_cmp++; if (cyc_q[b0] !== p + 2) begin n_err++; $display("FAIL single_latency: got %0d want %0d", cyc_q[b0] - p, 2); end
        end
    endtask

    task automatic test_multi_lane();
        logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h44};
        int b0 = byte_q.size();
        int p = cyc;
        push(2'b10, {32'h44434241, 32'h0}, 8'hB0);
        wait_bytes(b0 + 3, 80);
        n_cmp++; if (byte_q.size() !== b0 + 3) begin n_err++; $display("FAIL multi_count: got %0d want 3", byte_q.size() - b0); end
        if (byte_q.size() >= b0 + 3) begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (byte_q[b0+i] !== exp[i]) begin n_err++; $display("FAIL multi_byte%0d: got %0h want %0h", i, byte_q[b0+i], exp[i]); end
            end
            n_cmp++; if (cyc_q[b0] !== p + 2) begin n_err++; $display("FAIL multi_latency: got %0d want 2", cyc_q[b0] - p); end
            for (int i = 1; i < 3; i++) begin
                n_cmp++; if (gap_q[b0+i] !== 2) begin n_err++; $display("FAIL multi_gap%0d: got %0d want 2", i, gap_q[b0+i]); end
            end
        end
    endtask

    task automatic test_fairness();
        logic [7:0] exp [6] = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
        int b0 = byte_q.size();
        for (int k = 0; k < 3; k++) begin
            push(2'b11, {24'h0, 8'(8'h20 + k), 24'h0, 8'(8'h10 + k)}, 8'h11);
        end
        wait_bytes(b0 + 6, 150);
        n_cmp++; if (byte_q.size() !== b0 + 6) begin n_err++; $display("FAIL fair_count: got %0d want 6", byte_q.size() - b0); end
        if (byte_q.size() >= b0 + 6) begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++; if (byte_q[b0+i] !== exp[i]) begin n_err++; $display("FAIL fair_order%0d: got %0h want %0h", i, byte_q[b0+i], exp[i]); end
            end
        end
    endtask

    task automatic test_full_status();
        int b0 = byte_q.size();
        int bad = 0;
        hold_active = 1'b1;
        push(2'b01, 64'h01, 8'h01);
        step();
        for (int k = 0; k < 62; k++) push(2'b01, {56'h0, 8'(k + 2)}, 8'h01);
        n_cmp++; if (s_status[0] !== 1'b1) begin n_err++; $display("FAIL status_at62: got %b want 1", s_status[0]); end
        n_cmp++; if (s_wready[0] !== 1'b1) begin n_err++; $display("FAIL wready_at62: got %b want 1", s_wready[0]); end
        push(2'b01, 64'h40, 8'h01);
        n_cmp++; if (s_status !== 2'b10) begin n_err++; $display("FAIL status_at63: got %b want 10", s_status); end
        n_cmp++; if (s_wready[0] !== 1'b1) begin n_err++; $display("FAIL wready_at63: got %b want 1", s_wready[0]); end
        push(2'b01, 64'h41, 8'h01);
        n_cmp++; if (s_wready !== 2'b10) begin n_err++; $display("FAIL wready_at64: got %b want 10", s_wready); end
        push(2'b01, 64'hEE, 8'h01);
        n_cmp++; if (s_wready[0] !== 1'b0) begin n_err++; $display("FAIL wready_after_drop: got %b want 0", s_wready[0]); end
        n_cmp++; if (byte_q.size() !== b0) begin n_err++; $display("FAIL stall_no_dv: got %0d want 0", byte_q.size() - b0); end
        hold_active = 1'b0;
        wait_bytes(b0 + 65, 1500);
        n_cmp++; if (byte_q.size() !== b0 + 65) begin n_err++; $display("FAIL full_drain_count: got %0d want 65", byte_q.size() - b0); end
        if (byte_q.size() >= b0 + 65) begin
            for (int i = 0; i < 65; i++) if (byte_q[b0+i] !== 8'(i + 1)) bad++;
            n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL full_drain_order: got %0d wrong bytes want 0", bad); end
        end
    endtask

    task automatic test_zero_strobe();
        int b0 = byte_q.size();
        int p;
        push(2'b01, 64'h99, 8'h00);
        repeat (10) step();
        n_cmp++; if (byte_q.size() !== b0) begin n_err++; $display("FAIL zero_no_dv: got %0d pulses want 0", byte_q.size() - b0); end
        n_cmp++; if (s_status !== 2'b11) begin n_err++; $display("FAIL zero_status: got %b want 11", s_status); end
        p = cyc;
        push(2'b01, 64'h55, 8'h01);
        wait_bytes(b0 + 1, 40);
        n_cmp++; if (byte_q.size() !== b0 + 1) begin n_err++; $display("FAIL zero_next_count: got %0d want 1", byte_q.size() - b0); end
        if (byte_q.size() > b0) begin
            n_cmp++; if (byte_q[b0] !== 8'h55) begin n_err++; $display("FAIL zero_next_byte: got %0h want 55", byte_q[b0]); end
            n_cmp++; if (cyc_q[b0] !== p + 2) begin n_err++; $display("FAIL zero_next_latency: got %0d want 2", cyc_q[b0] - p); end
        end
    endtask

    task automatic test_reset_mid();
        int b0 = byte_q.size();
        int b1;
        int k = 0;
        push(2'b01, 64'h71, 8'h01);
        push(2'b11, {32'h73, 32'h72}, 8'h11);
        while (byte_q.size() < b0 + 1 && k < 40) begin
            step();
            k++;
        end
        n_cmp++; if (byte_q.size() !== b0 + 1) begin n_err++; $display("FAIL rstmid_first: got %0d want 1", byte_q.size() - b0); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (i_Tx_DV !== 1'b0) begin n_err++; $display("FAIL rstmid_dv: got %0h want 0", i_Tx_DV); end
        n_cmp++; if (i_Tx_Byte !== 8'h00) begin n_err++; $display("FAIL rstmid_byte: got %0h want 0", i_Tx_Byte); end
        n_cmp++; if (s_wready !== 2'b11) begin n_err++; $display("FAIL rstmid_wready: got %b want 11", s_wready); end
        n_cmp++; if (s_status !== 2'b11) begin n_err++; $display("FAIL rstmid_status: got %b want 11", s_status); end
        step();
        rst = 1'b0;
        repeat (20) step();
        n_cmp++; if (byte_q.size() !== b0 + 1) begin n_err++; $display("FAIL rstmid_flush: got %0d pulses want 1", byte_q.size() - b0); end
        b1 = byte_q.size();
        push(2'b11, {32'h82, 32'h81}, 8'h11);
        wait_bytes(b1 + 2, 60);
        n_cmp++; if (byte_q.size() !== b1 + 2) begin n_err++; $display("FAIL rstmid_after_count: got %0d want 2", byte_q.size() - b1); end
        if (byte_q.size() >= b1 + 2) begin
            n_cmp++; if (byte_q[b1] !== 8'h81) begin n_err++; $display("FAIL rstmid_ch0_first: got %0h want 81", byte_q[b1]); end
            n_cmp++; if (byte_q[b1+1] !== 8'h82) begin n_err++; $display("FAIL rstmid_ch1_second: got %0h want 82", byte_q[b1+1]); end
        end
    endtask

`ifdef UART_ARB_LINE_LOCK_EN
    task automatic test_line_lock();
        logic [7:0] exp [5] = '{8'h41, 8'h42, 8'h43, 8'h0A, 8'h31};
        int b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        b0 = byte_q.size();
        push(2'b11, {32'h31, 32'h4241}, 8'h13);
        push(2'b01, {32'h0, 32'h0A43}, 8'h03);
        wait_bytes(b0 + 5, 120);
        n_cmp++; if (byte_q.size() !== b0 + 5) begin n_err++; $display("FAIL lock_count: got %0d want 5", byte_q.size() - b0); end
        if (byte_q.size() >= b0 + 5) begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++; if (byte_q[b0+i] !== exp[i]) begin n_err++; $display("FAIL lock_order%0d: got %0h want %0h", i, byte_q[b0+i], exp[i]); end
            end
        end
    endtask
`endif

    initial begin
        s_wvalid = 2'b00;
        s_wdata  = '0;
        s_wstrb  = '0;
        test_reset();
        test_single_byte();
        test_multi_lane();
        test_fairness();
        test_full_status();
        test_zero_strobe();
        test_reset_mid();
`ifdef UART_ARB_LINE_LOCK_EN
        test_line_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
